// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the iteration count of the bit-serial datapath.
package mult_div_pkg;

    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// sign-correcting results.
module mdu_negate #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Bit-serial MIPS-style HI/LO multiply/divide unit: 32 shift-add or restoring
// steps on magnitudes, one sign-fix cycle, then a HI/LO writeback cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_t             state, next_state;
    logic [CNT_W-1:0]   count;
    op_t                op_q;
    logic               sign_a, sign_b, div_zero;
    logic [WIDTH-1:0]   a_raw, operand;
    logic [2*WIDTH-1:0] acc, acc_step, result_q, fixed;

    logic               in_signed, in_mult, mult_q;
    logic [WIDTH-1:0]   a_mag, b_mag, fix_rem;
    logic [2*WIDTH-1:0] fix_main;
    logic [WIDTH:0]     add_sum, div_cand, div_diff;

    assign in_signed = ~op[0];
    assign in_mult   = ~op[1];
    assign mult_q    = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign busy      = (state != IDLE);

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
        .value(a), .negate(in_signed & a[WIDTH-1]), .result(a_mag)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
        .value(b), .negate(in_signed & b[WIDTH-1]), .result(b_mag)
    );

    // Product, or quotient in the low half, takes the XOR of operand signs.
    mdu_negate #(.WIDTH(2*WIDTH)) u_fix_main (
        .value (mult_q ? acc : {{WIDTH{1'b0}}, acc[WIDTH-1:0]}),
        .negate(sign_a ^ sign_b),
        .result(fix_main)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .value(acc[2*WIDTH-1:WIDTH]), .negate(sign_a), .result(fix_rem)
    );

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        div_cand = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_cand - {1'b0, operand};
        if (mult_q)
            acc_step = {add_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        fixed = {fix_rem, fix_main[WIDTH-1:0]};
        if (mult_q)
            fixed = fix_main;
        else if (div_zero)
            fixed = {a_raw, {WIDTH{1'b1}}};
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (count == CNT_W'(ITERATIONS - 1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            op_q     <= OP_MULT;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            operand  <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    count    <= '0;
                    op_q     <= op_t'(op);
                    sign_a   <= in_signed & a[WIDTH-1];
                    sign_b   <= in_signed & b[WIDTH-1];
                    div_zero <= (b == '0);
                    a_raw    <= a;
                    operand  <= in_mult ? a_mag : b_mag;
                    acc      <= {{WIDTH{1'b0}}, (in_mult ? b_mag : a_mag)};
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIX:     result_q <= fixed;
                default: ;
            endcase
        end
    end

    // Start wins over a coincident MTHI/MTLO; writes are dropped while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                hi <= result_q[2*WIDTH-1:WIDTH];
                lo <= result_q[WIDTH-1:0];
            end else if (state == IDLE && !start) begin
                if (hi_we) hi <= wd;
                if (lo_we) lo <= wd;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO
// and completion cycle; a negedge monitor checks every done pulse.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic        busy, done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no completion", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Start edge is the next posedge; done is due 34 edges later.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x, y,
                         input logic [31:0] eh, el, input bit push, input bit mthi_too);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (mthi_too) begin
            hi_we = 1'b1;
            wd    = 32'h0000_5555;
        end
        if (push) sb.push_back('{eh, el, cyc + 1 + 34, name});
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        a     = ~x;
        b     = ~y;
        op    = ~o;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0; op = 2'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        issue("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1, 0);
        chk("busy_running", 64'(busy), 64'h1);
        drain();
        issue("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 0);
        drain();
        issue("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1, 0);
        drain();
        issue("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 0);
        drain();
        issue("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1, 0);
        drain();
        issue("divu_by0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0);
        drain();
        issue("div_neg_by0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 0);
        drain();

        // Second start during busy must be ignored: exactly one done.
        issue("multu_3_4", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1, 0);
        repeat (4) @(negedge clk);
        issue("ignored", DIVU, 32'd9, 32'd3, 32'd0, 32'd0, 0, 0);
        drain();
        repeat (40) @(negedge clk);

        @(negedge clk);
        hi_we = 1'b1; wd = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo_kept", 64'(lo), 64'd12);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hAABB_CCDD;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthlo_hi", 64'(hi), 64'hAABB_CCDD);
        chk("mthlo_lo", 64'(lo), 64'hAABB_CCDD);

        issue("multu_6_6", MULTU, 32'd6, 32'd6, 32'd0, 32'd36, 1, 0);
        repeat (3) @(negedge clk);
        lo_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_busy_dropped", 64'(lo), 64'hAABB_CCDD);
        drain();

        issue("start_vs_mthi", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1, 1);
        chk("mthi_dropped", 64'(hi), 64'h0);
        drain();

        issue("aborted", MULTU, 32'h10, 32'h10, 32'd0, 32'd0, 0, 0);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        issue("multu_6_7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/register width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  begin operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have port a  input  32  operand A / dividend, driven from register-file read port 1.
REQ-007 SHALL have port b  input  32  operand B / divisor, driven from register-file read port 2.
REQ-008 SHALL have port hi_we  input  1  MTHI write enable.
REQ-009 SHALL have port lo_we  input  1  MTLO write enable.
REQ-010 SHALL have port wd  input  32  MTHI/MTLO write data.
REQ-011 SHALL have port hi  output  32  HI register, feeds the MFHI path to register-file write data.
REQ-012 SHALL have port lo  output  32  LO register, feeds the MFLO path.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-016 SHALL move IDLE->RUN on a clock edge where start=1; SHALL latch a, b and op at that edge; later operand changes SHALL have no effect.
REQ-017 SHALL stay in RUN for exactly 32 cycles: one shift-add step (multiply) or one restoring step (divide) per cycle, operating on magnitudes.
REQ-018 SHALL do the sign correction (conditional two's-complement negate) in FIX, 1 cycle, then enter DONE.
REQ-019 SHALL, in DONE, update hi/lo, assert done for exactly 1 cycle, and return to IDLE.
REQ-020 SHALL assert done exactly 34 cycles after the start edge; hi/lo SHALL show the result in the same cycle as done.
REQ-021 SHALL drive busy=1 in RUN, FIX and DONE, and busy=0 in IDLE.
REQ-022 SHALL place the multiply result as 64-bit product with hi=[63:32], lo=[31:0]; MULT signed, MULTU unsigned.
REQ-023 SHALL place the divide result as lo=quotient, hi=remainder.
REQ-024 SHALL, for signed divide, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-025 SHALL, on divide by zero (either signedness), give lo=32'hFFFFFFFF and hi=latched a, with normal latency.
REQ-026 SHALL, on DIV 32'h80000000 / 32'hFFFFFFFF, give lo=32'h80000000 and hi=0 (wrap, no trap).
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL, in IDLE, apply hi_we/lo_we to hi/lo at the next edge; both may be written in the same cycle.
REQ-029 SHALL drop hi_we/lo_we while busy=1.
REQ-030 SHALL give start precedence when start and hi_we/lo_we coincide in IDLE: the write is dropped.
REQ-031 SHALL hold hi/lo unchanged in all other cases.

Reset
REQ-032 SHALL, on reset_n=0, immediately force FSM=IDLE, hi=0, lo=0, busy=0, done=0, and clear the iteration counter and internal datapath registers.
REQ-033 SHALL, on reset mid-operation, abort the operation with no done pulse; the first start after reset_n rises SHALL be accepted normally.

Structure
REQ-034 SHALL place the op encoding enum, the FSM state enum and the constant ITERATIONS=32 in package mult_div_pkg.
REQ-035 SHALL contain exactly one sub-module, mdu_negate (combinational conditional 64-bit two's-complement negate), used for both operand magnitude and result correction.

Verification
REQ-036 SHALL cover MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done 34 cycles after start.
REQ-037 SHALL cover MULT a=-3 b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIVU a=100 b=7 -> lo=14, hi=2.
REQ-038 SHALL cover DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-039 SHALL cover DIVU a=5 b=0 -> lo=32'hFFFFFFFF, hi=5; a second start pulse during busy -> ignored, exactly one done.
REQ-040 SHALL cover IDLE hi_we=1 wd=32'h12345678 -> hi=32'h12345678 next cycle; lo_we during busy -> lo ends as the operation result only.
REQ-041 SHALL cover reset_n low at cycle 10 of MULTU -> busy=0, hi=lo=0 immediately, no done; a new MULTU 6*7 -> lo=42, hi=0.
